riscv_bus_arbiter: RTL and testbench



---
 rtl/riscv_bus_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_riscv_bus_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_bus_arbiter.sv
// riscv_bus_arbiter
// Shares the single memory bus between the instruction-fetch port (F stage)
// and the data port (M stage). One transaction is outstanding at a time.
// Data requests win arbitration, except when a fetch has already lost
// MAX_IWAIT times, in which case the fetch is forced through. Every bus
// transaction carries a timeout; an expired transaction completes with
// o_bus_err. Stall outputs feed the hazard unit (M side) and the fetch
// stall (F side).
// MAX_IWAIT and TIMEOUT must both be at least 1.
module riscv_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_IWAIT = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch port
  input  logic                  i_ireq,
  input  logic [ADDR_W-1:0]     i_iaddr,
  input  logic                  i_iflush,
  output logic                  o_ivalid,
  output logic [DATA_W-1:0]     o_irdata,
  output logic                  o_istall,
  // data port
  input  logic                  i_dreq,
  input  logic                  i_dwe,
  input  logic [ADDR_W-1:0]     i_daddr,
  input  logic [DATA_W-1:0]     i_dwdata,
  input  logic [DATA_W/8-1:0]   i_dbe,
  output logic                  o_dvalid,
  output logic [DATA_W-1:0]     o_drdata,
  output logic                  o_bus_stallM,
  output logic                  o_bus_err,
  // memory bus
  output logic                  o_mreq,
  output logic                  o_mwe,
  output logic [ADDR_W-1:0]     o_maddr,
  output logic [DATA_W-1:0]     o_mwdata,
  output logic [DATA_W/8-1:0]   o_mbe,
  input  logic                  i_mack,
  input  logic [DATA_W-1:0]     i_mrdata
);

  localparam int BE_W   = DATA_W / 8;
  localparam int WAIT_W = $clog2(MAX_IWAIT + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_IWAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IBUS = 2'd1,
    ST_DBUS = 2'd2
  } state_t;

  state_t              state_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [TMO_W-1:0]    tmo_cnt_r;
  logic                cancel_r;

  logic                ireq_m_s;
  logic                dreq_m_s;
  logic                grant_i_s;
  logic                grant_d_s;
  logic                tmo_hit_s;
  logic                deliver_i_s;

  // A request is masked in the cycle its own valid pulse is out, so the
  // still-asserted request of a just-completed transaction is not re-issued.
  assign ireq_m_s = i_ireq & ~o_ivalid;
  assign dreq_m_s = i_dreq & ~o_dvalid;

  // Stalls drop exactly in the valid-pulse cycle.
  assign o_istall     = i_ireq & ~o_ivalid;
  assign o_bus_stallM = i_dreq & ~o_dvalid;

  assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

  // A fetch result is delivered only if no flush has been seen during it,
  // including a flush arriving in the completion cycle itself.
  assign deliver_i_s = ~(cancel_r | i_iflush);

  // Fixed data priority with a starvation guard for the fetch port.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (ireq_m_s && (!dreq_m_s || (wait_cnt_r >= WAIT_MAX))) begin
      grant_i_s = 1'b1;
    end else if (dreq_m_s) begin
      grant_d_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Arbiter FSM: issues the registered bus command and produces the
  // completion pulses, timeout error and fetch-cancel bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= {WAIT_W{1'b0}};
      tmo_cnt_r  <= {TMO_W{1'b0}};
      cancel_r   <= 1'b0;
      o_mreq     <= 1'b0;
      o_mwe      <= 1'b0;
      o_maddr    <= {ADDR_W{1'b0}};
      o_mwdata   <= {DATA_W{1'b0}};
      o_mbe      <= {BE_W{1'b0}};
      o_ivalid   <= 1'b0;
      o_dvalid   <= 1'b0;
      o_bus_err  <= 1'b0;
      o_irdata   <= {DATA_W{1'b0}};
      o_drdata   <= {DATA_W{1'b0}};
    end else begin
      // completion signals are single-cycle pulses
      o_ivalid  <= 1'b0;
      o_dvalid  <= 1'b0;
      o_bus_err <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          tmo_cnt_r <= {TMO_W{1'b0}};
          cancel_r  <= 1'b0;
          if (grant_i_s) begin
            state_r    <= ST_IBUS;
            o_mreq     <= 1'b1;
            o_mwe      <= 1'b0;
            o_maddr    <= i_iaddr;
            o_mwdata   <= {DATA_W{1'b0}};
            o_mbe      <= {BE_W{1'b1}};
            wait_cnt_r <= {WAIT_W{1'b0}};
          end else if (grant_d_s) begin
            state_r  <= ST_DBUS;
            o_mreq   <= 1'b1;
            o_mwe    <= i_dwe;
            o_maddr  <= i_daddr;
            o_mwdata <= i_dwdata;
            o_mbe    <= i_dbe;
            // the fetch lost this round; count it, saturating
            if (ireq_m_s && (wait_cnt_r < WAIT_MAX)) begin
              wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            end else begin
              wait_cnt_r <= wait_cnt_r;
            end
          end else begin
            state_r <= ST_IDLE;
            o_mreq  <= 1'b0;
          end
        end

        ST_IBUS: begin
          if (i_iflush) begin
            cancel_r <= 1'b1;
          end else begin
            cancel_r <= cancel_r;
          end
          if (i_mack) begin
            // ack wins over a coincident timeout
            o_irdata  <= i_mrdata;
            o_ivalid  <= deliver_i_s;
            state_r   <= ST_IDLE;
            o_mreq    <= 1'b0;
            tmo_cnt_r <= {TMO_W{1'b0}};
            cancel_r  <= 1'b0;
          end else if (tmo_hit_s) begin
            // abort: read data left unchanged
            o_ivalid  <= deliver_i_s;
            o_bus_err <= deliver_i_s;
            state_r   <= ST_IDLE;
            o_mreq    <= 1'b0;
            tmo_cnt_r <= {TMO_W{1'b0}};
            cancel_r  <= 1'b0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end

        ST_DBUS: begin
          if (i_mack) begin
            o_drdata  <= i_mrdata;
            o_dvalid  <= 1'b1;
            state_r   <= ST_IDLE;
            o_mreq    <= 1'b0;
            tmo_cnt_r <= {TMO_W{1'b0}};
          end else if (tmo_hit_s) begin
            o_dvalid  <= 1'b1;
            o_bus_err <= 1'b1;
            state_r   <= ST_IDLE;
            o_mreq    <= 1'b0;
            tmo_cnt_r <= {TMO_W{1'b0}};
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          o_mreq    <= 1'b0;
          tmo_cnt_r <= {TMO_W{1'b0}};
          cancel_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// Testbench for riscv_bus_arbiter: directed stimulus, a scripted memory
// responder and a scoreboard monitor that checks every bus command and every
// completion pulse (cycle, data, error) against queued expectations.
module tb_riscv_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_ireq, i_iflush, o_ivalid, o_istall;
  logic [AW-1:0] i_iaddr;
  logic [DW-1:0] o_irdata;
  logic          i_dreq, i_dwe, o_dvalid, o_bus_stallM, o_bus_err;
  logic [AW-1:0] i_daddr;
  logic [DW-1:0] i_dwdata, o_drdata;
  logic [BW-1:0] i_dbe;
  logic          o_mreq, o_mwe, i_mack;
  logic [AW-1:0] o_maddr;
  logic [DW-1:0] o_mwdata, i_mrdata;
  logic [BW-1:0] o_mbe;

  riscv_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_IWAIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_ireq(i_ireq), .i_iaddr(i_iaddr), .i_iflush(i_iflush),
    .o_ivalid(o_ivalid), .o_irdata(o_irdata), .o_istall(o_istall),
    .i_dreq(i_dreq), .i_dwe(i_dwe), .i_daddr(i_daddr), .i_dwdata(i_dwdata),
    .i_dbe(i_dbe), .o_dvalid(o_dvalid), .o_drdata(o_drdata),
    .o_bus_stallM(o_bus_stallM), .o_bus_err(o_bus_err),
    .o_mreq(o_mreq), .o_mwe(o_mwe), .o_maddr(o_maddr), .o_mwdata(o_mwdata),
    .o_mbe(o_mbe), .i_mack(i_mack), .i_mrdata(i_mrdata)
  );

  always #5 clk = ~clk;

  // cycle index: value seen at the negedge is the current cycle number
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [BW-1:0] be; } cmd_t;
  typedef struct { int cyc; logic [DW-1:0] data; bit chk_data; bit err; } rsp_t;
  typedef struct { int lat; logic [DW-1:0] data; } mem_t;

  cmd_t cmd_q[$];
  rsp_t irsp_q[$];
  rsp_t drsp_q[$];
  mem_t mem_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  bit force_ack = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_eq(name, 32'(act), 32'(exp));
  endtask

  task automatic exp_cmd(input int c, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be);
    cmd_t e;
    e.cyc = c; e.we = we; e.addr = a; e.wdata = wd; e.be = be;
    cmd_q.push_back(e);
  endtask

  task automatic exp_rsp(input bit is_d, input int c, input logic [DW-1:0] d,
                         input bit chk, input bit err);
    rsp_t e;
    e.cyc = c; e.data = d; e.chk_data = chk; e.err = err;
    if (is_d) drsp_q.push_back(e);
    else      irsp_q.push_back(e);
  endtask

  task automatic mem_rsp(input int lat, input logic [DW-1:0] d);
    mem_t e;
    e.lat = lat; e.data = d;
    mem_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares bus commands and completion pulses.
  task automatic monitor();
    cmd_t c;
    rsp_t r;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_mreq && !prev) begin
        if (cmd_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL bus_cmd: actual unexpected command addr %h, required none (cycle %0d)", o_maddr, cyc);
        end else begin
          c = cmd_q.pop_front();
          check_eq("cmd_cycle", cyc, c.cyc);
          check_bit("cmd_we", o_mwe, c.we);
          check_eq("cmd_addr", o_maddr, c.addr);
          check_eq("cmd_be", 32'(o_mbe), 32'(c.be));
          if (c.we) check_eq("cmd_wdata", o_mwdata, c.wdata);
        end
      end
      prev = o_mreq;
      if (o_dvalid) begin
        if (drsp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL dvalid: actual unexpected pulse, required none (cycle %0d)", cyc);
        end else begin
          r = drsp_q.pop_front();
          check_eq("dvalid_cycle", cyc, r.cyc);
          check_bit("d_bus_err", o_bus_err, r.err);
          if (r.chk_data) check_eq("drdata", o_drdata, r.data);
        end
      end
      if (o_ivalid) begin
        if (irsp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL ivalid: actual unexpected pulse, required none (cycle %0d)", cyc);
        end else begin
          r = irsp_q.pop_front();
          check_eq("ivalid_cycle", cyc, r.cyc);
          check_bit("i_bus_err", o_bus_err, r.err);
          if (r.chk_data) check_eq("irdata", o_irdata, r.data);
        end
      end
      if (o_bus_err && !o_dvalid && !o_ivalid) begin
        n_chk++; n_fail++;
        $display("FAIL bus_err: actual pulse without valid, required none (cycle %0d)", cyc);
      end
    end
  endtask

  // Memory model: acks each command after its scripted latency (0 = never).
  task automatic responder();
    mem_t cur;
    int   cnt = 0;
    cur.lat = 0; cur.data = 32'h0;
    forever begin
      @(negedge clk);
      if (o_mreq) begin
        if (cnt == 0) begin
          if (mem_q.size() > 0) cur = mem_q.pop_front();
          else begin cur.lat = 0; cur.data = 32'h0; end
        end
        cnt++;
        i_mack   = (cur.lat != 0) && (cnt == cur.lat);
        i_mrdata = i_mack ? cur.data : 32'h0BAD_F00D;
      end else begin
        cnt      = 0;
        i_mack   = force_ack;
        i_mrdata = 32'h0BAD_F00D;
      end
    end
  endtask

  // Bounded wait for a valid pulse; stall must be low in that cycle.
  task automatic wait_valid(input bit is_d, input int limit);
    bit seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (is_d ? o_dvalid : o_ivalid) begin
        seen = 1'b1;
        check_bit("stall_at_valid", is_d ? o_bus_stallM : o_istall, 1'b0);
      end
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL wait_valid: actual no pulse in %0d cycles, required pulse (port %s)", limit, is_d ? "D" : "I");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b1; i_ireq = 1'b0; i_iaddr = 32'h0; i_iflush = 1'b0;
    i_dreq = 1'b0; i_dwe = 1'b0; i_daddr = 32'h0; i_dwdata = 32'h0; i_dbe = 4'h0;
    i_mack = 1'b0; i_mrdata = 32'h0;
    fork
      monitor();
      responder();
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_mreq", o_mreq, 1'b0);
    check_bit("rst_mwe", o_mwe, 1'b0);
    check_bit("rst_ivalid", o_ivalid, 1'b0);
    check_bit("rst_dvalid", o_dvalid, 1'b0);
    check_bit("rst_bus_err", o_bus_err, 1'b0);
    check_eq("rst_maddr", o_maddr, 32'h0);
    check_eq("rst_mwdata", o_mwdata, 32'h0);
    check_eq("rst_mbe", 32'(o_mbe), 32'h0);
    check_eq("rst_irdata", o_irdata, 32'h0);
    check_eq("rst_drdata", o_drdata, 32'h0);
    step(); rst = 1'b0;

    // single load, ack in the third bus cycle
    step(); t = cyc;
    i_dreq = 1'b1; i_dwe = 1'b0; i_daddr = 32'h100; i_dbe = 4'hF;
    mem_rsp(3, 32'hDEAD_BEEF);
    exp_cmd(t + 1, 1'b0, 32'h100, 32'h0, 4'hF);
    exp_rsp(1'b1, t + 4, 32'hDEAD_BEEF, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_bit("load_stallM", o_bus_stallM, cyc <= t + 3);
      check_bit("load_mreq", o_mreq, (cyc >= t + 1) && (cyc <= t + 3));
    end
    step(); i_dreq = 1'b0;

    // simultaneous fetch and data write, ack latency 1: data first
    step(); t = cyc;
    i_ireq = 1'b1; i_iaddr = 32'h200;
    i_dreq = 1'b1; i_dwe = 1'b1; i_daddr = 32'h300; i_dwdata = 32'h1234_5678; i_dbe = 4'b0011;
    mem_rsp(1, 32'h0); mem_rsp(1, 32'hCAFE_0001);
    exp_cmd(t + 1, 1'b1, 32'h300, 32'h1234_5678, 4'b0011);
    exp_cmd(t + 3, 1'b0, 32'h200, 32'h0, 4'hF);
    exp_rsp(1'b1, t + 2, 32'h0, 1'b0, 1'b0);
    exp_rsp(1'b0, t + 4, 32'hCAFE_0001, 1'b1, 1'b0);
    wait_valid(1'b1, 10); step(); i_dreq = 1'b0; i_dwe = 1'b0;
    wait_valid(1'b0, 10); step(); i_ireq = 1'b0;

    // starvation guard: the fetch loses four rounds (withdrawing in between)
    for (int r = 0; r < 4; r++) begin
      step(); t = cyc;
      i_ireq = 1'b1; i_iaddr = 32'h400;
      i_dreq = 1'b1; i_dwe = 1'b0; i_dbe = 4'hF; i_daddr = 32'h500 + 32'd4 * 32'(r);
      mem_rsp(1, 32'hD000_0000 + 32'(r));
      exp_cmd(t + 1, 1'b0, 32'h500 + 32'd4 * 32'(r), 32'h0, 4'hF);
      exp_rsp(1'b1, t + 2, 32'hD000_0000 + 32'(r), 1'b1, 1'b0);
      step(); i_ireq = 1'b0;
      wait_valid(1'b1, 10);
    end
    // fifth round: fetch forced through, then data
    step(); t = cyc;
    i_ireq = 1'b1; i_iaddr = 32'h404; i_daddr = 32'h600;
    mem_rsp(1, 32'hF000_0004); mem_rsp(1, 32'hD000_0004);
    exp_cmd(t + 1, 1'b0, 32'h404, 32'h0, 4'hF);
    exp_cmd(t + 3, 1'b0, 32'h600, 32'h0, 4'hF);
    exp_rsp(1'b0, t + 2, 32'hF000_0004, 1'b1, 1'b0);
    exp_rsp(1'b1, t + 4, 32'hD000_0004, 1'b1, 1'b0);
    wait_valid(1'b0, 10); step(); i_ireq = 1'b0;
    wait_valid(1'b1, 10);
    // wait count was cleared: data wins again
    step(); t = cyc;
    i_ireq = 1'b1; i_iaddr = 32'h408; i_daddr = 32'h700;
    mem_rsp(1, 32'hD000_0005); mem_rsp(1, 32'hF000_0005);
    exp_cmd(t + 1, 1'b0, 32'h700, 32'h0, 4'hF);
    exp_cmd(t + 3, 1'b0, 32'h408, 32'h0, 4'hF);
    exp_rsp(1'b1, t + 2, 32'hD000_0005, 1'b1, 1'b0);
    exp_rsp(1'b0, t + 4, 32'hF000_0005, 1'b1, 1'b0);
    wait_valid(1'b1, 10); step(); i_dreq = 1'b0;
    wait_valid(1'b0, 10); step(); i_ireq = 1'b0;

    // flush during IBUS: result suppressed, redirected fetch issues next
    step(); t = cyc;
    i_ireq = 1'b1; i_iaddr = 32'h800;
    mem_rsp(3, 32'hBAD0_BAD0); mem_rsp(1, 32'h1111_2222);
    exp_cmd(t + 1, 1'b0, 32'h800, 32'h0, 4'hF);
    exp_cmd(t + 5, 1'b0, 32'h900, 32'h0, 4'hF);
    exp_rsp(1'b0, t + 6, 32'h1111_2222, 1'b1, 1'b0);
    step(); i_iflush = 1'b1;
    step(); i_iflush = 1'b0; i_iaddr = 32'h900;
    repeat (3) @(negedge clk);
    check_bit("flush_istall", o_istall, 1'b1);
    wait_valid(1'b0, 10); step(); i_ireq = 1'b0;

    // timeout (TIMEOUT=8), no ack: read data unchanged, error pulse
    step(); t = cyc;
    i_dreq = 1'b1; i_dwe = 1'b0; i_daddr = 32'hA00; i_dbe = 4'hF;
    mem_rsp(0, 32'h0);
    exp_cmd(t + 1, 1'b0, 32'hA00, 32'h0, 4'hF);
    exp_rsp(1'b1, t + 9, 32'hD000_0005, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_bit("tmo_mreq", o_mreq, (cyc >= t + 1) && (cyc <= t + 8));
    end
    step(); i_dreq = 1'b0;

    // ack in the timeout cycle: ack wins, no error
    step(); t = cyc;
    i_dreq = 1'b1; i_daddr = 32'hA04;
    mem_rsp(8, 32'h5A5A_5A5A);
    exp_cmd(t + 1, 1'b0, 32'hA04, 32'h0, 4'hF);
    exp_rsp(1'b1, t + 9, 32'h5A5A_5A5A, 1'b1, 1'b0);
    wait_valid(1'b1, 15); step(); i_dreq = 1'b0;

    // reset in DBUS cycle 2, then a stray ack in IDLE
    step(); t = cyc;
    i_dreq = 1'b1; i_daddr = 32'hB00;
    mem_rsp(0, 32'h0);
    exp_cmd(t + 1, 1'b0, 32'hB00, 32'h0, 4'hF);
    step(); step(); rst = 1'b1;
    step(); rst = 1'b0; i_dreq = 1'b0;
    @(negedge clk);
    check_bit("mid_rst_mreq", o_mreq, 1'b0);
    check_bit("mid_rst_dvalid", o_dvalid, 1'b0);
    check_bit("mid_rst_bus_err", o_bus_err, 1'b0);
    check_eq("mid_rst_maddr", o_maddr, 32'h0);
    check_eq("mid_rst_drdata", o_drdata, 32'h0);
    check_eq("mid_rst_irdata", o_irdata, 32'h0);
    step(); force_ack = 1'b1;
    step(); force_ack = 1'b0;
    @(negedge clk);
    check_bit("idle_ack_dvalid", o_dvalid, 1'b0);
    check_bit("idle_ack_mreq", o_mreq, 1'b0);
    check_eq("idle_ack_drdata", o_drdata, 32'h0);
    repeat (3) step();

    check_eq("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
    check_eq("irsp_q_empty", 32'(irsp_q.size()), 32'd0);
    check_eq("drsp_q_empty", 32'(drsp_q.size()), 32'd0);
    check_eq("mem_q_empty", 32'(mem_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
